d_ff_bist: RTL and testbench
============================

# d_ff_bist

Synchronous stimulus-and-check engine for the driving end of the `d_inter` D flip-flop interface. It plays the `tb1` role in hardware: it drives `d` and `reset` into a D flip-flop under test and samples `q`. It also runs a cycle-accurate reference model and counts mismatches. It sits beside a `d_ff` instance and lets self-test run without a simulation testbench.

## Interface
Parameters:
- `NUM_VECTORS`, 256: RUN-phase cycles per test (≥1).
- `SEED`, 16'hACE1: LFSR load value. 0 is replaced by 16'h0001.
- `RST_EVERY`, 0: inject a one-cycle DUT reset every `RST_EVERY` vectors. 0 disables injection.
- `CNT_W`, 16: width of the counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  system clock; the DUT shares it.
- `reset`  input  1  synchronous, active-high; returns the block to IDLE.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `dut_q`  input  1  DUT output `q`.
- `dut_d`  output  1  DUT data input `d`.
- `dut_reset`  output  1  DUT reset (the DUT treats it as async active-high).
- `busy`  output  1  high in RSTD, RUN and DRAIN.
- `done`  output  1  one-cycle pulse at test end.
- `pass`  output  1  high when the last completed test had `err_count==0`.
- `err_count`  output  CNT_W  mismatch count, saturating.
- `chk_count`  output  CNT_W  compare count, saturating.

## Operation
- States: IDLE → RSTD (2 cycles) → RUN (NUM_VECTORS cycles) → DRAIN (1 cycle) → DONE (1 cycle) → IDLE.
- IDLE:
  - `start=1` clears `err_count` and `chk_count`, loads the LFSR with SEED, clears `pass` and moves to RSTD.
  - `start` is ignored in every other state.
- RSTD: `dut_reset=1`, `dut_d=0`.
- RUN:
  - `dut_d = lfsr[0]`.
  - The LFSR advances every RUN cycle. It is a 16-bit Fibonacci LFSR, shift left; the new bit 0 is `lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]`.
  - A vector index counts 0..NUM_VECTORS-1.
  - If `RST_EVERY>0` and `index % RST_EVERY == RST_EVERY-1`, `dut_reset=1` for that cycle; otherwise it is 0.
- DRAIN: `dut_d=0`, `dut_reset=0`. Exists only to check the last vector.
- DONE: `done=1`, `pass = (err_count==0)`. `pass` holds until the next accepted `start`.
- Reference model: on every edge, `exp <= dut_reset ? 0 : dut_d`, using the values the block is currently driving.
- Compare:
  - Happens on every edge at which the state is RUN or DRAIN, so each test makes NUM_VECTORS+1 compares.
  - Each compare increments `chk_count`. `dut_q != exp` also increments `err_count`.
  - Both counters saturate at all-ones.
- Outputs `dut_d`, `dut_reset` and `done` are decoded from registered state and registered LFSR only. `dut_q` must not have a combinational path to any output.

## Timing
- Reset values:
  - state IDLE, `dut_d=0`, `dut_reset=1`. The DUT is held in reset while the block is in reset.
  - `busy=0`, `done=0`, `pass=0`, `err_count=0`, `chk_count=0`, LFSR=SEED.
- In IDLE after reset is released: `dut_reset=0`.
- Cycle timeline, with `start` sampled at edge E0:
  - RSTD after E0 and E1.
  - RUN after E2 through E(N+1).
  - DRAIN after E(N+2).
  - `done` high for the cycle after E(N+3).
  - IDLE after E(N+4).
- The first compare is at E3. It checks the reset value 0 that the DUT loaded at E2.
- A reset asserted mid-test takes effect at the next edge:
  - The block returns to IDLE with reset values and no `done` pulse.
  - `dut_reset` rises in the cycle after that edge.
- `start` asserted in the same cycle as `reset`: `reset` wins, and the `start` is lost.
- `start` held high across DONE: a new test begins on the first IDLE cycle.

## Test plan
- Ideal `d_ff`, N=8, SEED=16'hACE1, RST_EVERY=0: pulse `start` → `busy` for 11 cycles, `done` after E11, `chk_count=9`, `err_count=0`, `pass=1`; `dut_d` in the first RUN cycle is 1.
- `dut_q` tied to 1, N=8: pass=0. The E3 compare fails (exp=0). `err_count` equals the number of compares with exp=0 and is at least 1.
- Ideal DUT, N=12, RST_EVERY=4: `dut_reset` high in RUN indices 3, 7 and 11; `dut_q=0` on the following cycles; `err_count=0`.
- Assert `reset` at RUN index 5 → block returns to IDLE, no `done`, counters 0, `dut_reset=1` during reset. A fresh `start` then passes with `chk_count=N+1`.
- Pulse `start` during RUN → no effect, so the timeline is unchanged. Two back-to-back tests with `start` held high give identical `dut_d` sequences.
- CNT_W=2, `dut_q` stuck at 1, N=8 → `err_count` saturates at 3 and does not wrap; `chk_count` saturates at 3.

Source files
------------

// File: rtl/d_ff_bist.sv
// Stimulus-and-check engine for a D flip-flop: drives d/reset from an LFSR,
// tracks the expected q with a one-cycle reference model and counts mismatches.
module d_ff_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned RST_EVERY   = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_q,
  output logic             dut_d,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count
);

  localparam logic [15:0]      SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int unsigned      IdxW    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_VECTORS - 1);
  localparam int unsigned      RstW    = (RST_EVERY > 1) ? $clog2(RST_EVERY) : 1;
  localparam logic [RstW-1:0]  RstLast = RstW'((RST_EVERY > 0) ? RST_EVERY - 1 : 0);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [2:0] {StIdle, StRstd, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic             rstd_cnt_q, rstd_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [RstW-1:0]  rcnt_q, rcnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             exp_q;
  logic             hold_q;  // keeps the DUT in reset while this block is in reset
  logic [CNT_W-1:0] err_q, err_d, chk_q, chk_d;
  logic             pass_q, pass_d;
  logic             inject;
  logic             compare;

  assign inject    = (RST_EVERY > 0) && (rcnt_q == RstLast);
  assign compare   = (state_q == StRun) || (state_q == StDrain);

  assign dut_d     = (state_q == StRun) && lfsr_q[0];
  assign dut_reset = hold_q || (state_q == StRstd) || ((state_q == StRun) && inject);
  assign busy      = (state_q == StRstd) || (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign chk_count = chk_q;

  always_comb begin
    state_d    = state_q;
    rstd_cnt_d = rstd_cnt_q;
    idx_d      = idx_q;
    rcnt_d     = rcnt_q;
    lfsr_d     = lfsr_q;
    err_d      = err_q;
    chk_d      = chk_q;
    pass_d     = pass_q;

    if (compare) begin
      if (chk_q != CntMax) chk_d = chk_q + 1'b1;
      if ((dut_q != exp_q) && (err_q != CntMax)) err_d = err_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRstd;
          rstd_cnt_d = 1'b0;
          err_d      = '0;
          chk_d      = '0;
          lfsr_d     = SeedEff;
          pass_d     = 1'b0;
        end
      end
      StRstd: begin
        rstd_cnt_d = 1'b1;
        if (rstd_cnt_q) begin
          state_d = StRun;
          idx_d   = '0;
          rcnt_d  = '0;
        end
      end
      StRun: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_d  = idx_q + 1'b1;
        rcnt_d = (rcnt_q == RstLast) ? '0 : rcnt_q + 1'b1;
        if (idx_q == IdxLast) state_d = StDrain;
      end
      StDrain: begin
        state_d = StDone;
        // Include the final compare made on this same edge.
        pass_d  = (err_d == '0);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rstd_cnt_q <= 1'b0;
      idx_q      <= '0;
      rcnt_q     <= '0;
      lfsr_q     <= SeedEff;
      exp_q      <= 1'b0;
      hold_q     <= 1'b1;
      err_q      <= '0;
      chk_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rstd_cnt_q <= rstd_cnt_d;
      idx_q      <= idx_d;
      rcnt_q     <= rcnt_d;
      lfsr_q     <= lfsr_d;
      exp_q      <= dut_reset ? 1'b0 : dut_d;
      hold_q     <= 1'b0;
      err_q      <= err_d;
      chk_q      <= chk_d;
      pass_q     <= pass_d;
    end
  end

endmodule

// File: tb/tb_d_ff_bist.sv
// Scoreboarded random bench for d_ff_bist: three configurations, each beside a
// behavioural flip-flop whose q can be ideal, stuck or inverted.
module tb_d_ff_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  start, q, d, r, busy, done, pass;
  logic        ff [3];
  logic [1:0]  mode [3];
  logic [15:0] err_a, chk_a, err_b, chk_b;
  logic [1:0]  err_c, chk_c;

  int          n_err = 0;
  int          n_chk = 0;
  int          sel   = 0;

  d_ff_bist #(.NUM_VECTORS(8), .SEED(16'hACE1), .RST_EVERY(0), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .dut_q(q[0]), .dut_d(d[0]),
    .dut_reset(r[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_a), .chk_count(chk_a));

  d_ff_bist #(.NUM_VECTORS(12), .SEED(16'h0000), .RST_EVERY(4), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .dut_q(q[1]), .dut_d(d[1]),
    .dut_reset(r[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_b), .chk_count(chk_b));

  d_ff_bist #(.NUM_VECTORS(8), .SEED(16'h1234), .RST_EVERY(0), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .start(start[2]), .dut_q(q[2]), .dut_d(d[2]),
    .dut_reset(r[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err_c), .chk_count(chk_c));

  // Flop under test: async active-high reset; mode 0 ideal, 1 stuck-1, 2 stuck-0, 3 inverted.
  for (genvar g = 0; g < 3; g++) begin : g_ff
    always @(posedge clk or posedge r[g]) begin
      if (r[g]) ff[g] <= 1'b0;
      else      ff[g] <= d[g];
    end
    assign q[g] = (mode[g] == 2'd0) ? ff[g] : (mode[g] == 2'd1) ? 1'b1 :
                  (mode[g] == 2'd2) ? 1'b0 : ~ff[g];
  end

  logic        m_busy, m_done, m_pass, m_d, m_r;
  logic [15:0] m_err, m_chk;
  assign m_busy = busy[sel];
  assign m_done = done[sel];
  assign m_pass = pass[sel];
  assign m_d    = d[sel];
  assign m_r    = r[sel];
  always_comb begin
    m_err = err_a;
    m_chk = chk_a;
    if (sel == 1) begin
      m_err = err_b;
      m_chk = chk_b;
    end else if (sel == 2) begin
      m_err = {14'd0, err_c};
      m_chk = {14'd0, chk_c};
    end
  end

  typedef struct packed {logic d; logic r;} cyc_t;
  typedef struct packed {int unsigned err; int unsigned chk; logic pass; int unsigned len;} res_t;
  cyc_t cyc_q[$];
  res_t res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int fb;
    fb = (int'(s[15]) + int'(s[13]) + int'(s[12]) + int'(s[10])) % 2;
    return {s[14:0], fb[0]};
  endfunction

  // Reference: expected drive for every busy cycle plus the end-of-test counters.
  task automatic push_test(input int inst, input int md);
    int unsigned n, rev, cw, errs, maxv;
    logic [15:0] s;
    logic e [$];
    logic qv;
    res_t rr;
    case (inst)
      0:       begin n = 8;  rev = 0; cw = 16; s = 16'hACE1; end
      1:       begin n = 12; rev = 4; cw = 16; s = 16'h0001; end
      default: begin n = 8;  rev = 0; cw = 2;  s = 16'h1234; end
    endcase
    maxv = (1 << cw) - 1;
    e.push_back(1'b0);
    repeat (2) cyc_q.push_back('{d: 1'b0, r: 1'b1});
    for (int i = 0; i < int'(n); i++) begin
      logic dv, rv;
      dv = s[0];
      rv = (rev > 0) && ((i % rev) == rev - 1);
      cyc_q.push_back('{d: dv, r: rv});
      e.push_back(rv ? 1'b0 : dv);
      s = lfsr_next(s);
    end
    cyc_q.push_back('{d: 1'b0, r: 1'b0});
    errs = 0;
    foreach (e[k]) begin
      qv = (md == 0) ? e[k] : (md == 1) ? 1'b1 : (md == 2) ? 1'b0 : ~e[k];
      if (qv != e[k]) errs++;
    end
    rr.err  = (errs > maxv) ? maxv : errs;
    rr.chk  = (n + 1 > maxv) ? maxv : n + 1;
    rr.pass = (errs == 0);
    rr.len  = n + 3;
    res_q.push_back(rr);
  endtask

  // Monitor: consumes one expected drive per busy cycle, one result per done pulse.
  cyc_t        mc;
  res_t        mr;
  int unsigned busy_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (m_busy) begin
        busy_cnt++;
        if (cyc_q.size() == 0) check("busy_extra", 32'd1, 32'd0);
        else begin
          mc = cyc_q.pop_front();
          check("drive_d_reset", {30'd0, m_d, m_r}, {30'd0, mc.d, mc.r});
        end
      end
      if (m_done) begin
        if (res_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          mr = res_q.pop_front();
          check("busy_len", busy_cnt, mr.len);
          check("err_count", {16'd0, m_err}, mr.err);
          check("chk_count", {16'd0, m_chk}, mr.chk);
          check("pass", {31'd0, m_pass}, {31'd0, mr.pass});
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int inst, input bit noise);
    bit got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      if (m_done) got = 1;
      else begin
        start[inst] = noise && m_busy && ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end
    end
    start[inst] = 1'b0;
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_test(input int inst, input int md, input bit noise);
    sel       = inst;
    mode[inst] = 2'(md);
    push_test(inst, md);
    start[inst] = 1'b1;
    @(posedge clk); #1;
    start[inst] = 1'b0;
    wait_done(inst, noise);
    @(posedge clk); #1;
  endtask

  initial begin
    int md;
    reset = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) mode[i] = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check("rst_dut_reset", {31'd0, m_r}, 32'd1);
      check("rst_dut_d", {31'd0, m_d}, 32'd0);
      check("rst_busy_done_pass", {29'd0, m_busy, m_done, m_pass}, 32'd0);
      check("rst_counts", {m_err, m_chk}, 32'd0);
    end
    sel = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check("idle_dut_reset", {31'd0, m_r}, 32'd0);
    end

    run_test(0, 0, 0);  // ideal flop
    run_test(0, 1, 0);  // stuck at 1
    run_test(1, 0, 0);  // injected resets
    run_test(2, 1, 0);  // saturating 2-bit counters
    run_test(2, 3, 0);

    // Reset in RUN index 5: back to idle with cleared counters and no done.
    sel = 0; mode[0] = 2'd0;
    push_test(0, 0);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, m_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    cyc_q.delete();
    res_q.delete();
    check("mid_rst_dut_reset", {31'd0, m_r}, 32'd1);
    check("mid_rst_busy_done", {30'd0, m_busy, m_done}, 32'd0);
    check("mid_rst_counts", {m_err, m_chk}, 32'd0);
    check("mid_rst_pass", {31'd0, m_pass}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_idle_dut_reset", {31'd0, m_r}, 32'd0);
    run_test(0, 0, 0);

    // start held across DONE: second test follows on the first idle cycle.
    md = $urandom_range(0, 3);
    sel = 0; mode[0] = 2'(md);
    push_test(0, md);
    push_test(0, md);
    start[0] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 400 && !m_done; k++) begin
      @(posedge clk); #1;
    end
    check("held_first_done", {31'd0, m_done}, 32'd1);
    @(posedge clk); #1;
    check("held_idle_gap", {31'd0, m_busy}, 32'd0);
    @(posedge clk); #1;
    check("held_restart", {31'd0, m_busy}, 32'd1);
    start[0] = 1'b0;
    wait_done(0, 0);
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_test($urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end

    check("queues_empty", cyc_q.size() + res_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
